// File: rtl/game_step_sched.sv
// Frame-locked game scheduler: frame tick, speed-scaled update pulses, IDLE/RUN/PAUSE/OVER FSM, direction commit.
// Optional SCHED_SINGLE_STEP_EN: a step key rise in PAUSE emits one update at the next frame tick.
module game_step_sched #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int FRAMES_PER_STEP = 8,
  parameter int MIN_FRAMES      = 2,
  parameter int SPEED_SHIFT     = 2
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [1:0]  dir_in,
  input  logic        start,
  input  logic        pause,
  input  logic        step,
  input  logic        game_over,
  input  logic [7:0]  score,
  output logic        upd_pulse,
  output logic [1:0]  dir_out,
  output logic        game_rst,
  output logic [1:0]  state,
  output logic [15:0] step_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t      cur_state, nxt_state;
  logic        start_q, pause_q;
  logic        start_rise, pause_rise;
  logic        frame_tick;
  logic [7:0]  fcnt;
  logic [1:0]  pending_dir;
  logic [1:0]  reverse_dir;
  logic [7:0]  score_red;
  logic signed [8:0] period_raw, period, period_m1;
  logic        period_hit;
  logic        run_fire, step_fire, fire;
  logic        go_run, go_idle;

  assign state      = cur_state;
  assign frame_tick = (pix_x == 10'(H_ACTIVE - 1)) && (pix_y == 10'(V_ACTIVE - 1));
  assign start_rise = start & ~start_q;
  assign pause_rise = pause & ~pause_q;

  // Signed so a large score drives the raw period negative and the floor catches it.
  assign score_red  = score >> SPEED_SHIFT;
  assign period_raw = $signed(9'(FRAMES_PER_STEP)) - $signed({1'b0, score_red});
  assign period     = (period_raw < $signed(9'(MIN_FRAMES))) ? $signed(9'(MIN_FRAMES)) : period_raw;
  assign period_m1  = period - 9'sd1;
  assign period_hit = $signed({1'b0, fcnt}) >= period_m1;

  assign reverse_dir = {dir_out[1], ~dir_out[0]};
  assign run_fire    = (cur_state == S_RUN) && frame_tick && period_hit;
  assign fire        = run_fire | step_fire;
  assign go_run      = (cur_state == S_IDLE) && (nxt_state == S_RUN);
  assign go_idle     = (cur_state != S_IDLE) && (nxt_state == S_IDLE);

`ifdef SCHED_SINGLE_STEP_EN
  logic step_q, step_arm;
  logic step_rise;

  assign step_rise = step & ~step_q;
  assign step_fire = (cur_state == S_PAUSE) && frame_tick && step_arm;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      step_q   <= 1'b0;
      step_arm <= 1'b0;
    end else begin
      step_q <= step;
      if (nxt_state != S_PAUSE) begin
        step_arm <= 1'b0;
      end else if (step_fire) begin
        step_arm <= 1'b0;
      end else if (step_rise) begin
        step_arm <= 1'b1;
      end
    end
  end
`else
  logic unused_step;

  assign unused_step = step;
  assign step_fire   = 1'b0;
`endif

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:  if (start_rise) nxt_state = S_RUN;
      S_RUN: begin
        // game_over outranks a simultaneous pause press.
        if (game_over)       nxt_state = S_OVER;
        else if (pause_rise) nxt_state = S_PAUSE;
      end
      S_PAUSE: if (pause_rise) nxt_state = S_RUN;
      S_OVER:  if (start_rise) nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      cur_state   <= S_IDLE;
      game_rst    <= 1'b1;
      upd_pulse   <= 1'b0;
      dir_out     <= 2'b11;
      pending_dir <= 2'b00;
      fcnt        <= 8'd0;
      step_count  <= 16'd0;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      game_rst  <= (nxt_state == S_IDLE);
      upd_pulse <= fire;
      start_q   <= start;
      pause_q   <= pause;

      if (go_run) begin
        fcnt <= 8'd0;
      end else if ((cur_state == S_RUN) && frame_tick) begin
        fcnt <= period_hit ? 8'd0 : fcnt + 8'd1;
      end

      if (go_run) begin
        dir_out     <= 2'b11;
        pending_dir <= 2'b11;
      end else begin
        if (dir_in != reverse_dir) pending_dir <= dir_in;
        if (fire)                  dir_out     <= pending_dir;
      end

      if (go_idle) begin
        step_count <= 16'd0;
      end else if (fire && (step_count != 16'hFFFF)) begin
        step_count <= step_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_game_step_sched.sv
// Directed bench for game_step_sched: reset, period scaling, direction commit, pause/over and single-step.
module tb_game_step_sched;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  pix_x, pix_y;
  logic [1:0]  dir_in;
  logic        start, pause, step, game_over;
  logic [7:0]  score;
  logic        upd_pulse;
  logic [1:0]  dir_out;
  logic        game_rst;
  logic [1:0]  state;
  logic [15:0] step_count;

  int checks = 0;
  int passed = 0;

  always #5 vga_clk = ~vga_clk;

  game_step_sched dut (
    .vga_clk(vga_clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .dir_in(dir_in), .start(start), .pause(pause), .step(step),
    .game_over(game_over), .score(score), .upd_pulse(upd_pulse),
    .dir_out(dir_out), .game_rst(game_rst), .state(state), .step_count(step_count)
  );

  task automatic cyc();
    @(posedge vga_clk);
    #1;
  endtask

  // One cycle at the last active pixel; upd_pulse for this tick is visible on return.
  task automatic frame();
    pix_x = 10'd639;
    pix_y = 10'd479;
    cyc();
    pix_x = 10'd0;
    pix_y = 10'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; pause = 1'b0; step = 1'b0; game_over = 1'b0;
    dir_in = 2'b11; score = 8'd0; pix_x = 10'd0; pix_y = 10'd0;
    cyc(); cyc();
    reset = 1'b0;
    checks++; if (state !== 2'b00) $display("FAIL reset_state got %b want 00", state); else passed++;
    checks++; if (game_rst !== 1'b1) $display("FAIL reset_game_rst got %b want 1", game_rst); else passed++;
    checks++; if (upd_pulse !== 1'b0) $display("FAIL reset_upd got %b want 0", upd_pulse); else passed++;
    checks++; if (dir_out !== 2'b11) $display("FAIL reset_dir got %b want 11", dir_out); else passed++;
    checks++; if (step_count !== 16'd0) $display("FAIL reset_count got %0d want 0", step_count); else passed++;
    cyc();
    checks++; if (state !== 2'b01) $display("FAIL held_start_state got %b want 01", state); else passed++;
    checks++; if (game_rst !== 1'b0) $display("FAIL held_start_game_rst got %b want 0", game_rst); else passed++;
    checks++; if (dir_out !== 2'b11) $display("FAIL held_start_dir got %b want 11", dir_out); else passed++;
    start = 1'b0;
    cyc();
  endtask

  task automatic test_default_period();
    for (int i = 1; i <= 24; i++) begin
      frame();
      checks++;
      if (upd_pulse !== ((i % 8) == 0))
        $display("FAIL default_pulse frame %0d got %b want %b", i, upd_pulse, ((i % 8) == 0));
      else passed++;
    end
    cyc();
    checks++; if (upd_pulse !== 1'b0) $display("FAIL pulse_width got %b want 0", upd_pulse); else passed++;
    checks++; if (step_count !== 16'd3) $display("FAIL default_count got %0d want 3", step_count); else passed++;
  endtask

  task automatic test_speed();
    logic exp_p [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] sc [5] = '{8'd24, 8'd24, 8'd24, 8'd255, 8'd255};
    for (int i = 1; i <= 5; i++) begin
      frame();
      checks++; if (upd_pulse !== 1'b0) $display("FAIL speed_prefill frame %0d got %b want 0", i, upd_pulse); else passed++;
    end
    for (int i = 0; i < 5; i++) begin
      score = sc[i];
      frame();
      checks++;
      if (upd_pulse !== exp_p[i])
        $display("FAIL speed_pulse idx %0d score %0d got %b want %b", i, score, upd_pulse, exp_p[i]);
      else passed++;
    end
    score = 8'd0;
    checks++; if (step_count !== 16'd6) $display("FAIL speed_count got %0d want 6", step_count); else passed++;
  endtask

  task automatic test_direction();
    dir_in = 2'b10;
    for (int i = 1; i <= 8; i++) begin
      frame();
      checks++; if (upd_pulse !== (i == 8)) $display("FAIL dir_rev_pulse frame %0d got %b want %b", i, upd_pulse, (i == 8)); else passed++;
    end
    checks++; if (dir_out !== 2'b11) $display("FAIL dir_rev_only got %b want 11", dir_out); else passed++;
    cyc();
    dir_in = 2'b00;
    cyc();
    for (int i = 1; i <= 7; i++) frame();
    checks++; if (dir_out !== 2'b11) $display("FAIL dir_before_commit got %b want 11", dir_out); else passed++;
    frame();
    checks++; if (upd_pulse !== 1'b1) $display("FAIL dir_commit_pulse got %b want 1", upd_pulse); else passed++;
    checks++; if (dir_out !== 2'b00) $display("FAIL dir_commit got %b want 00", dir_out); else passed++;
    dir_in = 2'b01;
    for (int i = 1; i <= 8; i++) frame();
    checks++; if (upd_pulse !== 1'b1) $display("FAIL dir_down_pulse got %b want 1", upd_pulse); else passed++;
    checks++; if (dir_out !== 2'b00) $display("FAIL dir_down_rev got %b want 00", dir_out); else passed++;
    checks++; if (step_count !== 16'd9) $display("FAIL dir_count got %0d want 9", step_count); else passed++;
    dir_in = 2'b11;
  endtask

  task automatic test_pause_over();
    int pulses;
    for (int i = 1; i <= 3; i++) frame();
    pause = 1'b1; cyc();
    checks++; if (state !== 2'b10) $display("FAIL pause_enter got %b want 10", state); else passed++;
    pause = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin frame(); if (upd_pulse) pulses++; end
    checks++; if (pulses !== 0) $display("FAIL pause_pulses got %0d want 0", pulses); else passed++;
    pause = 1'b1; cyc();
    checks++; if (state !== 2'b01) $display("FAIL pause_resume got %b want 01", state); else passed++;
    pause = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 4; i++) begin frame(); if (upd_pulse) pulses++; end
    checks++; if (pulses !== 0) $display("FAIL resume_hold_pulses got %0d want 0", pulses); else passed++;
    frame();
    checks++; if (upd_pulse !== 1'b1) $display("FAIL resume_fcnt_held got %b want 1", upd_pulse); else passed++;
    checks++; if (step_count !== 16'd10) $display("FAIL pause_count got %0d want 10", step_count); else passed++;

    game_over = 1'b1; pause = 1'b1; cyc();
    checks++; if (state !== 2'b11) $display("FAIL over_priority got %b want 11", state); else passed++;
    game_over = 1'b0; pause = 1'b0; cyc();
    pause = 1'b1; cyc();
    checks++; if (state !== 2'b11) $display("FAIL over_pause_ignored got %b want 11", state); else passed++;
    pause = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin frame(); if (upd_pulse) pulses++; end
    checks++; if (pulses !== 0) $display("FAIL over_pulses got %0d want 0", pulses); else passed++;
    start = 1'b1; cyc();
    checks++; if (state !== 2'b00) $display("FAIL over_to_idle got %b want 00", state); else passed++;
    checks++; if (game_rst !== 1'b1) $display("FAIL idle_game_rst got %b want 1", game_rst); else passed++;
    checks++; if (step_count !== 16'd0) $display("FAIL idle_count got %0d want 0", step_count); else passed++;
    start = 1'b0; cyc();
  endtask

  task automatic test_single_step();
    int pulses;
    int exp_pulses;
`ifdef SCHED_SINGLE_STEP_EN
    exp_pulses = 1;
`else
    exp_pulses = 0;
`endif
    start = 1'b1; cyc();
    start = 1'b0; cyc();
    checks++; if (state !== 2'b01) $display("FAIL restart_state got %b want 01", state); else passed++;
    pause = 1'b1; cyc();
    pause = 1'b0; cyc();
    step = 1'b1; cyc();
    step = 1'b0; cyc();
    pulses = 0;
    for (int i = 1; i <= 22; i++) begin frame(); if (upd_pulse) pulses++; end
    checks++; if (pulses !== exp_pulses) $display("FAIL step_pulses got %0d want %0d", pulses, exp_pulses); else passed++;
    checks++; if (step_count !== 16'(exp_pulses)) $display("FAIL step_count got %0d want %0d", step_count, exp_pulses); else passed++;
    checks++; if (state !== 2'b10) $display("FAIL step_state got %b want 10", state); else passed++;
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_speed();
    test_direction();
    test_pause_over();
    test_single_step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/game_step_sched.md
Name: game_step_sched

Overview:
- Per-frame game scheduler between the VGA timing path and the game logic.
- Derives a frame tick from the scan coordinates and issues single-cycle game update pulses every N frames. N shrinks as score grows.
- Runs the top-level game state machine (IDLE/RUN/PAUSE/OVER) and commits player direction only at update boundaries, with reversal rejection.
- Replaces the free-running update clock divider; all logic is in the pixel clock domain.

Parameters:
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- FRAMES_PER_STEP, 8: frames per update at score 0; range 1..255.
- MIN_FRAMES, 2: floor on frames per update; 1 <= MIN_FRAMES <= FRAMES_PER_STEP.
- SPEED_SHIFT, 2: score is right-shifted by this amount to give the period reduction.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high.
- pix_x  in  10  current scan X from the VGA controller.
- pix_y  in  10  current scan Y from the VGA controller.
- dir_in  in  2  debounced key direction: 00 up, 01 down, 10 left, 11 right.
- start  in  1  start key level; edge-detected internally.
- pause  in  1  pause key level; edge-detected internally.
- step  in  1  single-step key level; used only with the optional feature.
- game_over  in  1  level from game logic.
- score  in  8  tail count from game logic.
- upd_pulse  out  1  one-cycle game update strobe.
- dir_out  out  2  committed direction.
- game_rst  out  1  holds game logic in reset while IDLE.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER.
- step_count  out  16  number of updates issued since leaving IDLE.

Behaviour:
- Reset values: state=IDLE, game_rst=1, upd_pulse=0, dir_out=11 (right), step_count=0. Frame counter, pending direction and edge-detect registers are also cleared. Reset takes priority over every other event in every state.
- frame_tick: an internal one-cycle strobe, true when pix_x==H_ACTIVE-1 and pix_y==V_ACTIVE-1.
- Edge detection: start, pause and step are registered once; a rise is prev=0, cur=1. The edge-detect registers are zero after reset, so a key held through reset gives an edge one cycle after reset release.
- State transitions (one cycle after the triggering edge):
  - IDLE -> RUN on start rise.
  - RUN -> OVER when game_over=1. This takes priority over a pause rise in the same cycle.
  - RUN -> PAUSE on pause rise.
  - PAUSE -> RUN on pause rise.
  - OVER -> IDLE on start rise.
  - All other edges are ignored. start is ignored in RUN and PAUSE; game_over is ignored outside RUN.
- game_rst = 1 exactly while state==IDLE (registered, same cycle as state).
- Period:
  - period = FRAMES_PER_STEP - (score >> SPEED_SHIFT), computed in 9-bit signed arithmetic.
  - If the result is < MIN_FRAMES, period = MIN_FRAMES.
  - period is re-evaluated at every frame_tick.
- Frame counter (8 bits):
  - Cleared on IDLE->RUN.
  - Held during PAUSE and OVER.
  - In RUN, on each frame_tick: if fcnt >= period-1, then fcnt=0 and upd_pulse=1 in the next cycle; otherwise fcnt increments. Using >= covers the period shrinking below the current count.
- upd_pulse is exactly one cycle wide, at most one per frame, and only asserted in RUN (plus the optional step case).
- step_count increments on each upd_pulse, saturates at 0xFFFF, and clears on entering IDLE.
- Direction:
  - pending_dir samples dir_in every cycle unless dir_in is the exact reverse of dir_out (up<->down, left<->right). A reverse is dropped and the previous pending value is kept.
  - dir_out <= pending_dir in the same cycle upd_pulse is asserted, so the change is visible alongside the pulse.
  - On IDLE->RUN, dir_out and pending_dir load 11.

Optional Feature:
- Macro: SCHED_SINGLE_STEP_EN.
- Defined: in PAUSE, a step rise arms a one-shot. The next frame_tick emits one upd_pulse with the direction commit, increments step_count, and disarms. fcnt is unchanged. Leaving PAUSE clears the arm.
- Undefined: the step input is ignored entirely and no extra registers are built. PAUSE never emits pulses.

Test Plan:
- Reset with start held high, then release -> state=00 and game_rst=1 for one cycle; start rise gives state=01 and game_rst=0 next cycle; dir_out=11.
- RUN, score=0, defaults -> upd_pulse on the 8th, 16th and 24th frame_tick only, each one cycle wide; step_count=3.
- score=24 -> period floors at 2, pulse every 2nd frame_tick. Changing score 0->24 mid-count with fcnt=5 -> pulse at the next frame_tick.
- dir_out=11, dir_in=10 (reverse) then 00 -> the 10 is dropped and dir_out=00 at the next upd_pulse. dir_in=10 alone -> dir_out stays 11.
- game_over and pause rise in the same cycle during RUN -> state=11. A later pause rise does nothing; start rise -> state=00, step_count=0.
- With SCHED_SINGLE_STEP_EN, in PAUSE, step rise -> exactly one upd_pulse at the next frame_tick and none after over 20 frames. Without the macro -> zero pulses.
